// File: rtl/segre_pkg.sv
// Shared types and sizes for the segre store buffer.
package segre_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int WORD_SIZE        = 32;
  localparam int SB_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_WRITE,
    SB_FLUSH
  } sb_state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]   addr;
    logic [WORD_SIZE-1:0]   data;
    logic [WORD_SIZE/8-1:0] be;
    logic                   valid;
  } sb_entry_t;

endpackage

// File: rtl/segre_store_buffer.sv
// Store buffer between MEM and the data cache: in-order FIFO of retired stores,
// load forwarding from the youngest matching entry, and a write/flush sequencer.
//
// state    | meaning
// SB_IDLE  | no cache write in flight
// SB_WRITE | opportunistic single write while the cache port is free
// SB_FLUSH | forced drain, keep writing until the buffer is empty
module segre_store_buffer
  import segre_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   push_i,
  input  logic [ADDR_SIZE-1:0]   st_addr_i,
  input  logic [WORD_SIZE-1:0]   st_data_i,
  input  logic [WORD_SIZE/8-1:0] st_be_i,
  input  logic                   ld_i,
  input  logic [ADDR_SIZE-1:0]   ld_addr_i,
  output logic                   ld_hit_o,
  output logic [WORD_SIZE-1:0]   ld_data_o,
  output logic                   ld_conflict_o,
  input  logic                   drain_i,
  input  logic                   dc_idle_i,
  output logic                   dc_wr_o,
  output logic [ADDR_SIZE-1:0]   dc_addr_o,
  output logic [WORD_SIZE-1:0]   dc_data_o,
  output logic [WORD_SIZE/8-1:0] dc_be_o,
  input  logic                   dc_ack_i,
  output logic                   store_buffer_draining_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(SB_DEPTH);

  sb_entry_t          entries_q [SB_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [PTR_W:0]     count_q, count_d;
  sb_state_t          state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic               push_ok, pop, flush_req, match;
  sb_entry_t          sel_entry, head_entry;

  assign full_o     = (count_q == (PTR_W+1)'(SB_DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop        = dc_wr_o && dc_ack_i;
  assign count_d    = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
  assign head_entry = entries_q[head_q];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        entries_q[tail_q] <= '{addr: st_addr_i, data: st_data_i, be: st_be_i, valid: 1'b1};
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    match     = 1'b0;
    sel_entry = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (entries_q[head_q + PTR_W'(k)].valid &&
          entries_q[head_q + PTR_W'(k)].addr[ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2]) begin
        match     = 1'b1;
        sel_entry = entries_q[head_q + PTR_W'(k)];
      end
    end
  end

  assign ld_hit_o      = ld_i && match && (&sel_entry.be);
  assign ld_conflict_o = ld_i && match && !(&sel_entry.be);
  assign ld_data_o     = ld_hit_o ? sel_entry.data : '0;

  assign flush_req = drain_i || full_o || ld_conflict_o;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= SB_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    flush_pend_d            = flush_pend_q;
    dc_wr_o                 = 1'b0;
    store_buffer_draining_o = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
        flush_pend_d = 1'b0;
        if (!empty_o && flush_req) begin
          state_d                 = SB_FLUSH;
          store_buffer_draining_o = 1'b1;
        end else if (!empty_o && dc_idle_i) begin
          state_d = SB_WRITE;
        end
      end
      SB_WRITE: begin
        dc_wr_o                 = 1'b1;
        store_buffer_draining_o = flush_pend_q;
        flush_pend_d            = flush_pend_q || flush_req;
        if (dc_ack_i) begin
          // A request arriving on the ack cycle itself is honoured too; nothing left means no flush.
          state_d      = ((flush_pend_q || flush_req) && count_d != '0) ? SB_FLUSH : SB_IDLE;
          flush_pend_d = 1'b0;
        end
      end
      SB_FLUSH: begin
        dc_wr_o                 = 1'b1;
        store_buffer_draining_o = 1'b1;
        if (dc_ack_i && count_d == '0) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  assign dc_addr_o = dc_wr_o ? head_entry.addr : '0;
  assign dc_data_o = dc_wr_o ? head_entry.data : '0;
  assign dc_be_o   = dc_wr_o ? head_entry.be   : '0;

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed bench for segre_store_buffer: write path, flush, forwarding, reset.
module tb_segre_store_buffer;
  import segre_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rsn_i;
  logic                   push_i;
  logic [ADDR_SIZE-1:0]   st_addr_i;
  logic [WORD_SIZE-1:0]   st_data_i;
  logic [WORD_SIZE/8-1:0] st_be_i;
  logic                   ld_i;
  logic [ADDR_SIZE-1:0]   ld_addr_i;
  logic                   ld_hit_o;
  logic [WORD_SIZE-1:0]   ld_data_o;
  logic                   ld_conflict_o;
  logic                   drain_i;
  logic                   dc_idle_i;
  logic                   dc_wr_o;
  logic [ADDR_SIZE-1:0]   dc_addr_o;
  logic [WORD_SIZE-1:0]   dc_data_o;
  logic [WORD_SIZE/8-1:0] dc_be_o;
  logic                   dc_ack_i;
  logic                   store_buffer_draining_o;
  logic                   full_o;
  logic                   empty_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  segre_store_buffer dut (
    .clk_i                   (clk_i),
    .rsn_i                   (rsn_i),
    .push_i                  (push_i),
    .st_addr_i               (st_addr_i),
    .st_data_i               (st_data_i),
    .st_be_i                 (st_be_i),
    .ld_i                    (ld_i),
    .ld_addr_i               (ld_addr_i),
    .ld_hit_o                (ld_hit_o),
    .ld_data_o               (ld_data_o),
    .ld_conflict_o           (ld_conflict_o),
    .drain_i                 (drain_i),
    .dc_idle_i               (dc_idle_i),
    .dc_wr_o                 (dc_wr_o),
    .dc_addr_o               (dc_addr_o),
    .dc_data_o               (dc_data_o),
    .dc_be_o                 (dc_be_o),
    .dc_ack_i                (dc_ack_i),
    .store_buffer_draining_o (store_buffer_draining_o),
    .full_o                  (full_o),
    .empty_o                 (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_push(input logic p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
    push_i    = p;
    st_addr_i = a;
    st_data_i = d;
    st_be_i   = b;
  endtask

  initial begin
    rsn_i = 1'b0; ld_i = 1'b0; ld_addr_i = '0; drain_i = 1'b0;
    dc_idle_i = 1'b0; dc_ack_i = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    chk_b("rst_dc_wr", dc_wr_o, 1'b0);
    chk_b("rst_empty", empty_o, 1'b1);
    chk_b("rst_full", full_o, 1'b0);
    chk_b("rst_drain", store_buffer_draining_o, 1'b0);
    chk_w("rst_dc_addr", dc_addr_o, 32'h0);
    chk_b("rst_ld_hit", ld_hit_o, 1'b0);
    @(negedge clk_i);
    rsn_i = 1'b1;
    tick();

    // single opportunistic write
    set_push(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    dc_idle_i = 1'b1;
    tick();
    push_i = 1'b0;
    #1;
    chk_b("w1_not_empty", empty_o, 1'b0);
    chk_b("w1_no_wr_yet", dc_wr_o, 1'b0);
    tick();
    chk_b("w1_dc_wr", dc_wr_o, 1'b1);
    chk_w("w1_addr", dc_addr_o, 32'h100);
    chk_w("w1_data", dc_data_o, 32'hDEADBEEF);
    chk_w("w1_be", 32'(dc_be_o), 32'hF);
    chk_b("w1_no_drain", store_buffer_draining_o, 1'b0);
    dc_ack_i = 1'b1;
    tick();
    dc_ack_i = 1'b0; dc_idle_i = 1'b0;
    #1;
    chk_b("w1_empty", empty_o, 1'b1);
    chk_b("w1_wr_drop", dc_wr_o, 1'b0);

    // fill to full, push-while-full ignored, in-order flush
    set_push(1'b1, 32'h110, 32'hAAAA0001, 4'hF);
    tick();
    set_push(1'b1, 32'h114, 32'hBBBB0002, 4'hF);
    tick();
    set_push(1'b1, 32'h118, 32'hCCCC0003, 4'hF);
    #1;
    chk_b("f_full", full_o, 1'b1);
    chk_b("f_drain_same_cycle", store_buffer_draining_o, 1'b1);
    chk_b("f_idle_no_wr", dc_wr_o, 1'b0);
    tick();
    push_i = 1'b0;
    #1;
    chk_b("f_wr", dc_wr_o, 1'b1);
    chk_w("f_addr0", dc_addr_o, 32'h110);
    chk_w("f_data0", dc_data_o, 32'hAAAA0001);
    dc_ack_i = 1'b1;
    tick();
    chk_w("f_addr1", dc_addr_o, 32'h114);
    chk_w("f_data1", dc_data_o, 32'hBBBB0002);
    chk_b("f_drain_mid", store_buffer_draining_o, 1'b1);
    tick();
    dc_ack_i = 1'b0;
    #1;
    chk_b("f_empty", empty_o, 1'b1);
    chk_b("f_drain_fall", store_buffer_draining_o, 1'b0);
    chk_b("f_no_third_write", dc_wr_o, 1'b0);

    // forwarding: same-cycle push excluded, full hit, miss, ld_i low
    set_push(1'b1, 32'h200, 32'h11223344, 4'hF);
    ld_i = 1'b1; ld_addr_i = 32'h200;
    #1;
    chk_b("fw_same_cycle", ld_hit_o, 1'b0);
    tick();
    push_i = 1'b0;
    #1;
    chk_b("fw_hit", ld_hit_o, 1'b1);
    chk_w("fw_data", ld_data_o, 32'h11223344);
    chk_b("fw_no_conf", ld_conflict_o, 1'b0);
    ld_addr_i = 32'h204;
    #1;
    chk_b("fw_miss", ld_hit_o, 1'b0);
    chk_w("fw_miss_data", ld_data_o, 32'h0);
    ld_i = 1'b0; ld_addr_i = 32'h200;
    #1;
    chk_b("fw_no_ld", ld_hit_o, 1'b0);
    // youngest of two same-word stores wins
    set_push(1'b1, 32'h200, 32'h55555555, 4'hF);
    tick();
    push_i = 1'b0; ld_i = 1'b1;
    #1;
    chk_w("fw_youngest", ld_data_o, 32'h55555555);
    tick();
    ld_i = 1'b0; dc_ack_i = 1'b1;
    tick();
    tick();
    dc_ack_i = 1'b0;
    #1;
    chk_b("fw_flushed", empty_o, 1'b1);

    // partial-byte match forces a flush
    set_push(1'b1, 32'h300, 32'h55667788, 4'h3);
    tick();
    push_i = 1'b0; ld_i = 1'b1; ld_addr_i = 32'h302;
    #1;
    chk_b("cf_conflict", ld_conflict_o, 1'b1);
    chk_b("cf_no_hit", ld_hit_o, 1'b0);
    chk_b("cf_drain", store_buffer_draining_o, 1'b1);
    tick();
    ld_i = 1'b0;
    #1;
    chk_b("cf_flush_wr", dc_wr_o, 1'b1);
    chk_w("cf_flush_be", 32'(dc_be_o), 32'h3);
    dc_ack_i = 1'b1;
    tick();
    dc_ack_i = 1'b0;
    #1;
    chk_b("cf_empty", empty_o, 1'b1);
    chk_b("cf_idle", dc_wr_o, 1'b0);

    // drain during a write latches a pending flush
    set_push(1'b1, 32'h400, 32'h0A0A0A0A, 4'hF);
    dc_idle_i = 1'b1;
    tick();
    push_i = 1'b0;
    tick();
    dc_idle_i = 1'b0;
    chk_b("dw_write", dc_wr_o, 1'b1);
    chk_b("dw_no_drain_yet", store_buffer_draining_o, 1'b0);
    drain_i = 1'b1;
    set_push(1'b1, 32'h404, 32'h0B0B0B0B, 4'hF);
    tick();
    drain_i = 1'b0; push_i = 1'b0;
    #1;
    chk_b("dw_pend_drain", store_buffer_draining_o, 1'b1);
    chk_w("dw_addr_stable", dc_addr_o, 32'h400);
    dc_ack_i = 1'b1;
    tick();
    chk_b("dw_flush_drain", store_buffer_draining_o, 1'b1);
    chk_w("dw_flush_addr", dc_addr_o, 32'h404);
    tick();
    dc_ack_i = 1'b0;
    #1;
    chk_b("dw_empty", empty_o, 1'b1);
    chk_b("dw_drain_fall", store_buffer_draining_o, 1'b0);

    // drain on an empty buffer does nothing
    drain_i = 1'b1;
    #1;
    chk_b("de_no_drain", store_buffer_draining_o, 1'b0);
    tick();
    drain_i = 1'b0;
    chk_b("de_no_wr", dc_wr_o, 1'b0);

    // asynchronous reset in the middle of a flush
    set_push(1'b1, 32'h500, 32'h50505050, 4'hF);
    tick();
    set_push(1'b1, 32'h504, 32'h50505054, 4'hF);
    tick();
    push_i = 1'b0;
    tick();
    chk_b("ar_wr_before", dc_wr_o, 1'b1);
    #2;
    rsn_i = 1'b0;
    #1;
    chk_b("ar_wr_drop", dc_wr_o, 1'b0);
    chk_b("ar_empty", empty_o, 1'b1);
    chk_b("ar_full", full_o, 1'b0);
    chk_b("ar_drain", store_buffer_draining_o, 1'b0);
    @(negedge clk_i);
    rsn_i = 1'b1; dc_idle_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("ar_no_write", dc_wr_o, 1'b0);
    end
    chk_b("ar_still_empty", empty_o, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
